reduce_serial: RTL
==================

// Module: reduce_serial
// PURPOSE
//  Sequential, parametrised bit-reduction engine: accepts an INPUT_WIDTH word over a
//  valid/ready handshake and reduces it CHUNK_WIDTH bits per cycle to one result bit.
//  Reduction mode is selectable per transaction (AND/OR/XOR/NAND).
//  Multi-cycle replacement for the combinational AND-chain reducers where wide
//  operands would break timing. Sits between operand buffers and flag/condition logic.
// PARAMETERS
//  INPUT_WIDTH  16  operand width in bits; >=1
//  CHUNK_WIDTH  4   bits reduced per cycle; 1..INPUT_WIDTH, must divide INPUT_WIDTH
//  NUM_CHUNKS   derived localparam = INPUT_WIDTH/CHUNK_WIDTH; counter width = clog2(NUM_CHUNKS)+1
// PORTS
//  clock        in   1            single clock, all logic on rising edge
//  reset        in   1            synchronous, active-high
//  inputData    in   INPUT_WIDTH  operand
//  inputMode    in   2            00 AND, 01 OR, 10 XOR, 11 NAND; sampled at accept
//  inputValid   in   1            operand offered
//  inputReady   out  1            engine can accept (high only in IDLE)
//  outputData   out  1            reduction result
//  outputValid  out  1            result offered
//  outputReady  in   1            consumer takes result
//  busy         out  1            high in BUSY or DONE
// BEHAVIOUR
//  - Reset: state=IDLE; inputReady=1 from the first cycle after reset; outputData=0,
//    outputValid=0, busy=0; shift register, accumulator, chunk counter cleared.
//  - FSM: IDLE -> BUSY on inputValid&&inputReady (capture inputData into shift reg,
//    inputMode into mode reg, accumulator=identity: 1 for AND/NAND, 0 for OR/XOR,
//    counter=0). inputValid while not IDLE is ignored (no capture).
//  - BUSY: each cycle combine low CHUNK_WIDTH bits of shift reg into accumulator
//    (AND/OR/XOR of acc with reduced chunk), shift right by CHUNK_WIDTH, counter++.
//    After chunk NUM_CHUNKS-1 is consumed -> DONE.
//  - DONE: outputValid=1, outputData=acc (inverted for NAND). Holds stable until
//    outputValid&&outputReady; then -> IDLE. No accept in the handshake cycle.
//  - Latency: accept at edge T -> outputValid high after edge T+NUM_CHUNKS.
//    Throughput: one result per NUM_CHUNKS+2 cycles with outputReady tied high.
//  - Chunks consumed LSB first; result independent of order for all modes.
//  - NUM_CHUNKS=1 (CHUNK_WIDTH=INPUT_WIDTH): single BUSY cycle, then DONE.
//  - outputReady high while not DONE: no effect.
//  - reset mid-BUSY or mid-DONE: transaction dropped, no result emitted, IDLE next cycle.
//  - outputData/outputValid registered; inputReady and busy decoded from state reg only.
// CONFIGURATION
//  REDUCE_SERIAL_EARLY_EXIT_EN defined: in BUSY, if mode is AND/NAND and chunk
//    reduction is 0, or mode is OR and chunk reduction is 1, go to DONE next cycle
//    (result is dominant value); remaining chunks skipped. XOR never exits early.
//    Latency becomes 1..NUM_CHUNKS cycles.
//  Not defined: always exactly NUM_CHUNKS BUSY cycles; no early-exit logic.
// TESTING  (INPUT_WIDTH=16, CHUNK_WIDTH=4 unless stated)
//  1 reset 2 cycles -> inputReady=1, outputValid=0, outputData=0, busy=0.
//  2 AND, inputData=16'hFFFF accepted at T -> outputValid after T+4, outputData=1;
//    16'h7FFF -> outputData=0 after T+4 (both builds; dominant 0 in last chunk).
//  3 XOR 16'h0007 -> 1; NAND 16'hFFFF -> 0; OR 16'h0000 -> 0; all after T+4.
//  4 backpressure: outputReady=0 for 3 cycles in DONE -> outputValid/outputData
//    stable, inputReady=0, second inputValid ignored; outputReady=1 -> IDLE next cycle.
//  5 reset asserted 2 cycles after accept -> no outputValid ever for that operand;
//    inputReady=1 first cycle after reset deasserts.
//  6 EARLY_EXIT_EN: AND 16'hFFF0 -> outputValid after T+1, outputData=0; OR 16'h0010
//    -> after T+2, =1; XOR 16'h0001 -> after T+4. Without macro: all after T+4.
//    Also INPUT_WIDTH=CHUNK_WIDTH=8: AND 8'hFF -> 1 after T+1.

Source files
------------

// File: rtl/reduce_serial.sv
// rtl/reduce_serial.sv - serial AND/OR/XOR/NAND bit reducer, CHUNK_WIDTH bits per cycle
// Optional early exit on a dominant chunk: REDUCE_SERIAL_EARLY_EXIT_EN
module reduce_serial #(
    parameter int INPUT_WIDTH = 16,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INPUT_WIDTH-1:0] inputData,
    input  logic [1:0]             inputMode,
    input  logic                   inputValid,
    output logic                   inputReady,
    output logic                   outputData,
    output logic                   outputValid,
    input  logic                   outputReady,
    output logic                   busy
);
    localparam int NUM_CHUNKS = INPUT_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = $clog2(NUM_CHUNKS) + 1;

    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_NAND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]             mode_q, mode_d;
    logic                   acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;

    logic [CHUNK_WIDTH-1:0] chunk;
    logic                   chunk_red;
    logic                   acc_next;
    logic                   last_chunk;
    logic                   early_exit;

    always_comb begin
        chunk      = shift_q[CHUNK_WIDTH-1:0];
        chunk_red  = 1'b0;
        acc_next   = acc_q;
        case (mode_q)
            MODE_OR: begin
                chunk_red = |chunk;
                acc_next  = acc_q | chunk_red;
            end
            MODE_XOR: begin
                chunk_red = ^chunk;
                acc_next  = acc_q ^ chunk_red;
            end
            default: begin
                chunk_red = &chunk;
                acc_next  = acc_q & chunk_red;
            end
        endcase
        last_chunk = (cnt_q == CNT_W'(NUM_CHUNKS - 1));
`ifdef REDUCE_SERIAL_EARLY_EXIT_EN
        // A dominant chunk fixes the result; XOR has no dominant value.
        early_exit = ((mode_q == MODE_AND || mode_q == MODE_NAND) && !chunk_red) ||
                     ((mode_q == MODE_OR) && chunk_red);
`else
        early_exit = 1'b0;
`endif

        state_d     = state_q;
        shift_d     = shift_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (inputValid) begin
                    state_d = S_BUSY;
                    shift_d = inputData;
                    mode_d  = inputMode;
                    acc_d   = (inputMode == MODE_AND) || (inputMode == MODE_NAND);
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                acc_d   = acc_next;
                shift_d = shift_q >> CHUNK_WIDTH;
                cnt_d   = cnt_q + 1'b1;
                if (last_chunk || early_exit) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_next ^ (mode_q == MODE_NAND);
                end
            end
            S_DONE: begin
                if (outputReady) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            mode_q      <= MODE_AND;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign inputReady  = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign outputData  = out_data_q;
    assign outputValid = out_valid_q;

endmodule
